// File: rtl/synth_pkg.sv
// Shared constants for the voice bank: command codes, field widths and the
// per-semitone phase-increment table for the lowest octave.
package synth_pkg;

  localparam int NOTE_W   = 7;
  localparam int VEL_W    = 7;
  localparam int PHASE_W  = 32;
  localparam int SAMPLE_W = 24;

  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_ON     = 2'b01;
  localparam logic [1:0] CMD_OFF    = 2'b10;
  localparam logic [1:0] CMD_ALLOFF = 2'b11;

  // round(440 * 2^((k-69)/12) * 2^32 / 96000), notes 0..11
  function automatic logic [PHASE_W-1:0] base_inc_96k(input logic [3:0] k);
    case (k)
      4'd0:    return 32'd365779;
      4'd1:    return 32'd387529;
      4'd2:    return 32'd410573;
      4'd3:    return 32'd434987;
      4'd4:    return 32'd460853;
      4'd5:    return 32'd488256;
      4'd6:    return 32'd517290;
      4'd7:    return 32'd548049;
      4'd8:    return 32'd580638;
      4'd9:    return 32'd615165;
      4'd10:   return 32'd651744;
      4'd11:   return 32'd690499;
      default: return 32'd0;
    endcase
  endfunction

  // Rescale the 96 kHz table to another sample rate (exact at 96 kHz).
  function automatic logic [PHASE_W-1:0] base_inc(input logic [3:0] k, input int fs_hz);
    return PHASE_W'((64'(base_inc_96k(k)) * 64'd96000 + 64'(fs_hz / 2)) / 64'(fs_hz));
  endfunction

endpackage

// File: rtl/bank_manager_voice_gen.sv
// One sawtooth voice: note/velocity registers, 32-bit phase accumulator and
// the velocity-scaled sample taken from the phase before it advances.
module voice_gen
  import synth_pkg::*;
#(
  parameter int FS_HZ = 96000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic                       start,
  input  logic                       stop,
  input  logic [NOTE_W-1:0]          note_in,
  input  logic [VEL_W-1:0]           vel_in,
  output logic                       busy,
  output logic [NOTE_W-1:0]          note,
  output logic signed [SAMPLE_W-1:0] sample
);

  logic                busy_q,  busy_d;
  logic [NOTE_W-1:0]   note_q,  note_d;
  logic [VEL_W-1:0]    vel_q,   vel_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;

  logic [PHASE_W-1:0]  inc_tab [16];
  logic [3:0]          semi;
  logic [3:0]          octave;
  logic [PHASE_W-1:0]  inc;
  logic signed [SAMPLE_W-1:0] prod;

  for (genvar k = 0; k < 16; k++) begin : g_tab
    assign inc_tab[k] = base_inc(4'(k), FS_HZ);
  end

  assign semi   = 4'(note_q % 7'd12);
  assign octave = 4'(note_q / 7'd12);
  assign inc    = inc_tab[semi] << octave;

  assign prod   = $signed(phase_q[PHASE_W-1 -: 16]) * $signed({1'b0, vel_q});
  assign sample = busy_q ? prod : '0;
  assign busy   = busy_q;
  assign note   = note_q;

  // A command on the same edge as clk_en wins over the phase advance.
  always_comb begin
    busy_d  = busy_q;
    note_d  = note_q;
    vel_d   = vel_q;
    phase_d = phase_q;
    if (clk_en && busy_q) phase_d = phase_q + inc;
    if (stop) begin
      busy_d  = 1'b0;
      phase_d = '0;
    end
    if (start) begin
      busy_d  = 1'b1;
      note_d  = note_in;
      vel_d   = vel_in;
      phase_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      note_q  <= '0;
      vel_q   <= '0;
      phase_q <= '0;
    end else begin
      busy_q  <= busy_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/bank_manager.sv
// Polyphonic sawtooth bank: decodes note commands, allocates/steals voices and
// produces the saturated sum of all voices once per sample enable.
module bank_manager
  import synth_pkg::*;
#(
  parameter int NVOICES = 4,
  parameter int FS_HZ   = 96000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_en,
  input  logic [15:0]                i_data,
  output logic signed [SAMPLE_W-1:0] o_signal
);

  localparam int PTR_W = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam int SUM_W = SAMPLE_W + PTR_W;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(8388607);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-8388608);

  logic [1:0]          cmd;
  logic [NOTE_W-1:0]   cmd_note;
  logic [VEL_W-1:0]    cmd_vel;
  logic                note_on, note_off, all_off;

  logic [NVOICES-1:0]  busy, match, start, stop;
  logic [NOTE_W-1:0]   vnote   [NVOICES];
  logic signed [SAMPLE_W-1:0] vsample [NVOICES];

  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    target;
  logic signed [SAMPLE_W-1:0] sig_q, sig_d;
  logic signed [SUM_W-1:0]    sum;

  assign cmd      = i_data[15:14];
  assign cmd_note = i_data[13:7];
  assign cmd_vel  = i_data[6:0];
  assign note_on  = (cmd == CMD_ON) && (cmd_vel != '0);
  assign note_off = (cmd == CMD_OFF) || ((cmd == CMD_ON) && (cmd_vel == '0));
  assign all_off  = (cmd == CMD_ALLOFF);

  for (genvar v = 0; v < NVOICES; v++) begin : g_voice
    voice_gen #(.FS_HZ(FS_HZ)) u_voice (
      .clk     (clk),
      .reset   (reset),
      .clk_en  (clk_en),
      .start   (start[v]),
      .stop    (stop[v]),
      .note_in (cmd_note),
      .vel_in  (cmd_vel),
      .busy    (busy[v]),
      .note    (vnote[v]),
      .sample  (vsample[v])
    );
    assign match[v] = busy[v] && (vnote[v] == cmd_note);
  end

  assign stop = all_off ? '1 : (note_off ? match : '0);

  // Retrigger beats free allocation, which beats stealing; only a steal moves the pointer.
  always_comb begin
    start  = '0;
    ptr_d  = ptr_q;
    target = ptr_q;
    if (note_on) begin
      if (|match) begin
        for (int i = NVOICES - 1; i >= 0; i--)
          if (match[i]) target = PTR_W'(i);
      end else if (!(&busy)) begin
        for (int i = NVOICES - 1; i >= 0; i--)
          if (!busy[i]) target = PTR_W'(i);
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
      start[target] = 1'b1;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NVOICES; i++)
      sum = sum + SUM_W'(vsample[i]);
    sig_d = sig_q;
    if (clk_en) begin
      if (sum > SAT_MAX)      sig_d = SAT_MAX[SAMPLE_W-1:0];
      else if (sum < SAT_MIN) sig_d = SAT_MIN[SAMPLE_W-1:0];
      else                    sig_d = sum[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      sig_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      sig_q <= sig_d;
    end
  end

  assign o_signal = sig_q;

endmodule

// File: tb/tb_bank_manager.sv
// Directed and randomized checks of bank_manager against an arithmetic voice-pool model.
module tb_bank_manager;

  localparam int NV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_en = 1'b0;
  logic [15:0] i_data = 16'h0000;
  logic [23:0] o_signal;

  int n_cmp = 0;
  int n_err = 0;

  bank_manager #(.NVOICES(NV), .FS_HZ(96000)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .i_data   (i_data),
    .o_signal (o_signal)
  );

  always #5 clk = ~clk;

  // reference model state
  bit [31:0]   base [12];
  bit          m_busy  [NV];
  int          m_note  [NV];
  int          m_vel   [NV];
  bit [31:0]   m_phase [NV];
  int          m_ptr;
  logic [23:0] m_sig;

  function automatic bit [31:0] m_inc(int n);
    bit [31:0] b;
    b = base[n % 12];
    return b << (n / 12);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NV; i++) begin
      m_busy[i] = 0; m_note[i] = 0; m_vel[i] = 0; m_phase[i] = 0;
    end
    m_ptr = 0;
    m_sig = 24'd0;
  endfunction

  function automatic void m_cmd(logic [15:0] d);
    int c, n, v, tgt;
    c = int'(d[15:14]);
    n = int'(d[13:7]);
    v = int'(d[6:0]);
    if (c == 1 && v != 0) begin
      tgt = -1;
      for (int i = 0; i < NV; i++)
        if (m_busy[i] && m_note[i] == n) tgt = i;
      if (tgt < 0)
        for (int i = NV - 1; i >= 0; i--)
          if (!m_busy[i]) tgt = i;
      if (tgt < 0) begin
        tgt = m_ptr;
        m_ptr = (m_ptr + 1) % NV;
      end
      m_busy[tgt] = 1; m_note[tgt] = n; m_vel[tgt] = v; m_phase[tgt] = 0;
    end else if (c == 2 || c == 1) begin
      for (int i = 0; i < NV; i++)
        if (m_busy[i] && m_note[i] == n) begin
          m_busy[i] = 0; m_phase[i] = 0;
        end
    end else if (c == 3) begin
      for (int i = 0; i < NV; i++) begin
        m_busy[i] = 0; m_phase[i] = 0;
      end
    end
  endfunction

  function automatic void m_edge(logic [15:0] d, logic en, logic r);
    longint acc;
    if (r) begin
      m_reset();
      return;
    end
    if (en) begin
      acc = 0;
      for (int i = 0; i < NV; i++) begin
        logic [15:0] hi;
        hi = m_phase[i][31:16];
        if (m_busy[i]) acc += longint'($signed(hi)) * longint'(m_vel[i]);
      end
      if (acc > 8388607) acc = 8388607;
      if (acc < -8388608) acc = -8388608;
      m_sig = 24'(acc);
      for (int i = 0; i < NV; i++)
        if (m_busy[i]) m_phase[i] = m_phase[i] + m_inc(m_note[i]);
    end
    m_cmd(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input logic [15:0] d, input logic en, input logic r);
    i_data = d; clk_en = en; reset = r;
    @(posedge clk);
    m_edge(d, en, r);
    #1;
    chk("o_signal", 32'(o_signal), 32'(m_sig));
  endtask

  function automatic logic [15:0] on_word(int n, int v);
    return {2'b01, 7'(n), 7'(v)};
  endfunction

  function automatic logic [15:0] off_word(int n);
    return {2'b10, 7'(n), 7'd0};
  endfunction

  initial begin
    bit saw_pos, saw_neg;
    for (int k = 0; k < 12; k++) begin
      real f;
      f = 440.0 * (2.0 ** ((real'(k) - 69.0) / 12.0));
      base[k] = 32'($rtoi(f * 4294967296.0 / 96000.0 + 0.5));
    end
    m_reset();

    // reset held with clk_en high
    for (int i = 0; i < 10; i++) begin
      step(16'h0000, 1'b1, 1'b1);
      chk("reset_zero", 32'(o_signal), 32'd0);
    end

    // note 69 velocity 127: 0, 0, 38100, 76200
    step(16'h62FF, 1'b1, 1'b0);
    chk("a4_cmd_edge", 32'(o_signal), 32'd0);
    step(16'h0000, 1'b1, 1'b0);
    chk("a4_first", 32'(o_signal), 32'd0);
    step(16'h0000, 1'b1, 1'b0);
    chk("a4_second", 32'(o_signal), 32'd38100);
    step(16'h0000, 1'b1, 1'b0);
    chk("a4_third", 32'(o_signal), 32'd76200);

    // clk_en low freezes output and phase
    for (int i = 0; i < 5; i++) begin
      step(16'h0000, 1'b0, 1'b0);
      chk("freeze", 32'(o_signal), 32'd76200);
    end
    step(16'h0000, 1'b1, 1'b0);
    chk("resume", 32'(o_signal), 32'd114427);
    step(16'h0000, 1'b1, 1'b0);

    // note-off 69 and velocity-0 note-on both free the voice
    step(16'hA280, 1'b0, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    chk("off_zero", 32'(o_signal), 32'd0);
    step(16'h62FF, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(16'h6280, 1'b0, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    chk("vel0_zero", 32'(o_signal), 32'd0);

    // allocation and stealing
    step(on_word(60, 100), 1'b1, 1'b0);
    step(on_word(62, 90), 1'b1, 1'b0);
    step(on_word(64, 80), 1'b1, 1'b0);
    step(on_word(65, 70), 1'b1, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    step(on_word(67, 60), 1'b1, 1'b0);
    chk("steal_ptr", 32'(u_dut.ptr_q), 32'(m_ptr));
    chk("steal_voice0", 32'(u_dut.g_voice[0].u_voice.note_q), 32'd67);
    step(off_word(60), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(16'h0000, 1'b1, 1'b0);

    // all-off with every voice busy
    step(16'hC000, 1'b0, 1'b0);
    step(16'h0000, 1'b1, 1'b0);
    chk("alloff_zero", 32'(o_signal), 32'd0);

    // four low notes rising together drive the sum past both rails
    for (int n = 0; n < 4; n++) step(on_word(n, 127), 1'b0, 1'b0);
    saw_pos = 0; saw_neg = 0;
    for (int i = 0; i < 6200; i++) begin
      step(16'h0000, 1'b1, 1'b0);
      if (o_signal === 24'h7FFFFF) saw_pos = 1;
      if (o_signal === 24'h800000) saw_neg = 1;
    end
    chk("pos_saturated", 32'(saw_pos), 32'd1);
    chk("neg_saturated", 32'(saw_neg), 32'd1);
    step(16'hC000, 1'b1, 1'b0);

    // randomized commands, enables and occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] d;
      int r, n, v;
      r = int'($urandom_range(0, 99));
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : 60 + int'($urandom_range(0, 7));
      v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      if (r < 45)      d = 16'h0000;
      else if (r < 75) d = on_word(n, v);
      else if (r < 95) d = off_word(n);
      else             d = 16'hC000;
      step(d, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 499) == 0));
    end
    chk("final_ptr", 32'(u_dut.ptr_q), 32'(m_ptr));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
